// File: rtl/branch_predictor_if.sv
// Fetch-lookup and EX-resolve signal bundle between the pipeline and branch_predictor.
// The pipeline is the master side; branch_predictor uses the slave modport.
interface branch_predictor_if;
  logic [31:0] PCF;
  logic        PredF;
  logic [31:0] NPC_PredF;
  logic [31:0] PCE;
  logic        ValidE;
  logic        BrInstE;
  logic        BranchE;
  logic [31:0] BranchTarget;
  logic        PredE;
  logic [31:0] PredTargetE;
  logic [1:0]  Pred_Error;
  logic [31:0] BrCnt;
  logic [31:0] MissCnt;

  modport slave (
    input  PCF, PCE, ValidE, BrInstE, BranchE, BranchTarget, PredE, PredTargetE,
    output PredF, NPC_PredF, Pred_Error, BrCnt, MissCnt
  );

  modport master (
    output PCF, PCE, ValidE, BrInstE, BranchE, BranchTarget, PredE, PredTargetE,
    input  PredF, NPC_PredF, Pred_Error, BrCnt, MissCnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit BHT: 0-cycle fetch lookup, EX resolve/redirect, table trained on clk edge.
// No backpressure: the caller gates ValidE so each resolving branch is presented exactly once.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter bit PREDICT_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bp
);
  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [31:0]         target;
    logic [1:0]          ctr;
  } entry_t;

  entry_t r_tbl [ENTRIES];
  logic [31:0] r_br_cnt;
  logic [31:0] r_miss_cnt;

  logic [INDEX_BITS-1:0] w_idx_f;
  logic [TAG_BITS-1:0]   w_tag_f;
  entry_t                w_ent_f;
  logic                  w_hit_f;

  logic [INDEX_BITS-1:0] w_idx_e;
  logic [TAG_BITS-1:0]   w_tag_e;
  entry_t                w_ent_e;
  logic                  w_hit_e;
  logic                  w_rv;
  logic [1:0]            w_err;
  entry_t                w_ent_nxt;
  logic                  w_upd;
  logic                  w_unused;

  assign w_unused = ^{bp.PCF[1:0], bp.PCE[1:0]};

  // Fetch lookup
  assign w_idx_f = bp.PCF[INDEX_BITS+1:2];
  assign w_tag_f = bp.PCF[31:INDEX_BITS+2];
  assign w_ent_f = r_tbl[w_idx_f];
  assign w_hit_f = w_ent_f.valid && (w_ent_f.tag == w_tag_f);

  assign bp.PredF     = PREDICT_EN && w_hit_f && w_ent_f.ctr[1];
  assign bp.NPC_PredF = w_ent_f.target;

  // EX resolve
  assign w_idx_e = bp.PCE[INDEX_BITS+1:2];
  assign w_tag_e = bp.PCE[31:INDEX_BITS+2];
  assign w_ent_e = r_tbl[w_idx_e];
  assign w_hit_e = w_ent_e.valid && (w_ent_e.tag == w_tag_e);
  assign w_rv    = bp.ValidE && bp.BrInstE;

  assign w_err[0] = w_rv && bp.BranchE &&
                    (!bp.PredE || (bp.PredTargetE != bp.BranchTarget));
  assign w_err[1] = w_rv && !bp.BranchE && bp.PredE;
  assign bp.Pred_Error = w_err;

  // Next contents of the EX-indexed entry; a not-taken miss leaves the table alone.
  always_comb begin
    w_ent_nxt = w_ent_e;
    w_upd     = 1'b0;
    if (w_rv) begin
      if (w_hit_e) begin
        w_upd = 1'b1;
        if (bp.BranchE) begin
          w_ent_nxt.ctr    = (w_ent_e.ctr == 2'b11) ? 2'b11 : w_ent_e.ctr + 2'd1;
          w_ent_nxt.target = bp.BranchTarget;
        end else begin
          w_ent_nxt.ctr    = (w_ent_e.ctr == 2'b00) ? 2'b00 : w_ent_e.ctr - 2'd1;
        end
      end else if (bp.BranchE) begin
        w_upd            = 1'b1;
        w_ent_nxt.valid  = 1'b1;
        w_ent_nxt.tag    = w_tag_e;
        w_ent_nxt.target = bp.BranchTarget;
        w_ent_nxt.ctr    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_tbl[i] <= '0;
      end
    end else if (w_upd) begin
      r_tbl[w_idx_e] <= w_ent_nxt;
    end
  end

  // Statistics saturate rather than wrap so long runs never report a bogus low count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_rv && (r_br_cnt != 32'hFFFF_FFFF)) begin
        r_br_cnt <= r_br_cnt + 32'd1;
      end
      if (w_rv && (|w_err) && (r_miss_cnt != 32'hFFFF_FFFF)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign bp.BrCnt   = r_br_cnt;
  assign bp.MissCnt = r_miss_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios then randomized traffic against a table model.
module tb_branch_predictor;
  localparam int IB  = 6;
  localparam int ENT = 1 << IB;

  logic clk;
  logic rst;

  branch_predictor_if bp_if ();

  branch_predictor #(.INDEX_BITS(IB), .PREDICT_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: one record per table slot, plain integers.
  bit          m_valid [ENT];
  int unsigned m_tag   [ENT];
  int unsigned m_tgt   [ENT];
  int          m_ctr   [ENT];
  longint      m_br;
  longint      m_miss;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input int unsigned pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic int unsigned tag_of(input int unsigned pc);
    return pc >> (IB + 2);
  endfunction

  function automatic bit m_hit(input int unsigned pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred(input int unsigned pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
    end
    m_br = 0; m_miss = 0;
  endtask

  // One cycle: apply inputs, check combinational outputs and counters, then train the model.
  task automatic step(input int unsigned pcf, input bit v, input bit bi, input bit tk,
                      input int unsigned bt, input int unsigned pce, input bit pe,
                      input int unsigned pt);
    bit       rv;
    bit       ep;
    bit [1:0] ee;
    int       k;
    @(negedge clk);
    bp_if.PCF = pcf; bp_if.ValidE = v; bp_if.BrInstE = bi; bp_if.BranchE = tk;
    bp_if.BranchTarget = bt; bp_if.PCE = pce; bp_if.PredE = pe; bp_if.PredTargetE = pt;
    #1;
    rv    = v && bi;
    ep    = m_pred(pcf);
    ee[0] = rv && tk && (!pe || pt != bt);
    ee[1] = rv && !tk && pe;
    chk("PredF", bp_if.PredF, ep);
    if (ep) chk("NPC_PredF", bp_if.NPC_PredF, m_tgt[idx_of(pcf)]);
    chk("Pred_Error", bp_if.Pred_Error, ee);
    chk("BrCnt", bp_if.BrCnt, m_br);
    chk("MissCnt", bp_if.MissCnt, m_miss);
    @(posedge clk);
    if (rv) begin
      k = idx_of(pce);
      m_br++;
      if (ee != 2'b00) m_miss++;
      if (m_hit(pce)) begin
        if (tk) begin
          m_ctr[k] = (m_ctr[k] + 1 > 3) ? 3 : m_ctr[k] + 1;
          m_tgt[k] = bt;
        end else begin
          m_ctr[k] = (m_ctr[k] - 1 < 0) ? 0 : m_ctr[k] - 1;
        end
      end else if (tk) begin
        m_valid[k] = 1; m_tag[k] = tag_of(pce); m_tgt[k] = bt; m_ctr[k] = 2;
      end
    end
    #1;
  endtask

  // Lookup-only cycle with constant expectations (no resolving branch).
  task automatic look(input string tag, input int unsigned pcf, input bit ep,
                      input int unsigned et);
    @(negedge clk);
    bp_if.PCF = pcf; bp_if.ValidE = 1'b0; bp_if.BrInstE = 1'b0;
    #1;
    chk({tag, "_PredF"}, bp_if.PredF, ep);
    if (ep) chk({tag, "_NPC"}, bp_if.NPC_PredF, et);
  endtask

  task automatic rand_step();
    int unsigned pce, pcf, bt, pt;
    bit pe;
    pce = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
    pcf = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
    bt  = $urandom_range(0, 7) << 4;
    if ($urandom_range(0, 3) != 0) begin
      pe = m_pred(pce);
      pt = m_tgt[idx_of(pce)];
    end else begin
      pe = 1'($urandom_range(0, 1));
      pt = $urandom_range(0, 7) << 4;
    end
    step(pcf, $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
         1'($urandom_range(0, 1)), bt, pce, pe, pt);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_reset();
    bp_if.PCF = 32'h100; bp_if.PCE = '0; bp_if.ValidE = 1'b0; bp_if.BrInstE = 1'b0;
    bp_if.BranchE = 1'b0; bp_if.BranchTarget = '0; bp_if.PredE = 1'b0; bp_if.PredTargetE = '0;
    rst = 1'b1;
    #1;
    chk("rst_PredF", bp_if.PredF, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    look("post_rst", 32'h100, 1'b0, 0);
    chk("post_rst_BrCnt", bp_if.BrCnt, 0);
    chk("post_rst_MissCnt", bp_if.MissCnt, 0);

    // First taken branch allocates with weak-taken counter.
    step(32'h0, 1, 1, 1, 32'h40, 32'h100, 0, 0);
    chk("alloc_err", bp_if.Pred_Error, 2'b01);
    look("alloc", 32'h100, 1'b1, 32'h40);
    chk("alloc_MissCnt", bp_if.MissCnt, 1);

    // Two more taken saturate at strong-taken; then a not-taken redirects to PCE+4.
    step(32'h0, 1, 1, 1, 32'h40, 32'h100, 1, 32'h40);
    chk("hit_ok_err", bp_if.Pred_Error, 2'b00);
    step(32'h0, 1, 1, 1, 32'h40, 32'h100, 1, 32'h40);
    step(32'h0, 1, 1, 0, 32'h40, 32'h100, 1, 32'h40);
    chk("nt_err", bp_if.Pred_Error, 2'b10);
    look("ctr10", 32'h100, 1'b1, 32'h40);

    // Two not-taken bring the counter to strong-not-taken.
    step(32'h0, 1, 1, 0, 32'h40, 32'h100, 1, 32'h40);
    step(32'h0, 1, 1, 0, 32'h40, 32'h100, 0, 32'h40);
    look("ctr00", 32'h100, 1'b0, 0);

    // Not-taken miss must not allocate.
    step(32'h0, 1, 1, 0, 32'h80, 32'h200, 0, 0);
    chk("nt_miss_err", bp_if.Pred_Error, 2'b00);
    look("nt_miss", 32'h200, 1'b0, 0);

    // Wrong predicted target on a taken branch redirects to BranchTarget.
    step(32'h0, 1, 1, 1, 32'h40, 32'h100, 1, 32'h44);
    chk("tgt_err", bp_if.Pred_Error, 2'b01);
    step(32'h0, 1, 1, 1, 32'h40, 32'h100, 0, 0);
    look("retrain", 32'h100, 1'b1, 32'h40);

    // Aliasing: 0x200 shares the slot and evicts 0x100.
    step(32'h0, 1, 1, 1, 32'h80, 32'h200, 0, 0);
    look("alias_old", 32'h100, 1'b0, 0);
    look("alias_new", 32'h200, 1'b1, 32'h80);

    // Non-branch with a stale prediction is not corrected and not counted.
    step(32'h0, 1, 0, 0, 32'h0, 32'h200, 1, 32'h80);
    chk("nonbr_err", bp_if.Pred_Error, 2'b00);

    // Same-slot lookup and update: old view this cycle, new view next.
    step(32'h300, 1, 1, 1, 32'h500, 32'h300, 0, 0);
    look("same_cyc", 32'h300, 1'b1, 32'h500);

    for (int i = 0; i < 400; i++) rand_step();

    // Asynchronous reset mid-cycle clears everything immediately.
    @(negedge clk);
    bp_if.ValidE = 1'b0;
    bp_if.PCF = 32'h300;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_PredF", bp_if.PredF, 1'b0);
    chk("mid_rst_BrCnt", bp_if.BrCnt, 0);
    chk("mid_rst_MissCnt", bp_if.MissCnt, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    look("after_rst", 32'h300, 1'b0, 0);

    for (int i = 0; i < 200; i++) rand_step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
